// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller.
//   tap_state_e : 4-bit TAP state, using the conventional 1149.1 encodings so
//                 the debug 'state' port matches common JTAG tooling.
//   OP_*        : instruction opcodes. BYPASS is all-ones, and any opcode not
//                 listed here also decodes as BYPASS.
//   IR_CAPTURE  : the pattern loaded into the IR shift stage in CAP_IR.
//   tap_next()  : the TAP state graph, advanced on tms.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SHF_DR = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SHF_IR = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam int unsigned OP_EXTEST = 0;
  localparam int unsigned OP_SAMPLE = 1;
  localparam int unsigned OP_IDCODE = 2;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SHF_DR;
      SHF_DR: n = tms ? EX1_DR : SHF_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SHF_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SHF_IR;
      SHF_IR: n = tms ? EX1_IR : SHF_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SHF_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_bsr_cell.sv
// One boundary-scan cell: a capture/shift flop feeding an update flop,
// followed by the normal/test output mux.
//   clk, rst   : TCK and synchronous active-high reset
//   clear      : synchronous clear of the update stage (TAP is in or entering TLR)
//   capture    : load the shift stage from sys_in
//   shift      : load the shift stage from scan_in
//   update     : copy the shift stage into the update stage
//   mode       : 1 drives sys_out from the update stage, 0 passes sys_in through
//   sys_in     : core-side value
//   scan_in    : serial input from the next cell towards tdi
//   scan_out   : this cell's shift stage, towards tdo
//   sys_out    : pin-side value
module jtag_bsr_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic mode,
  input  logic sys_in,
  input  logic scan_in,
  output logic scan_out,
  output logic sys_out
);

  logic cap_q;
  logic upd_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; this is what makes the chain shift by one.
  always_ff @(posedge clk) begin
    if (rst)          cap_q <= 1'b0;
    else if (capture) cap_q <= sys_in;
    else if (shift)   cap_q <= scan_in;
  end

  // The update stage is the only one the pins can see, so it is cleared on TLR
  // as well as on reset. The pins never glitch during shifting.
  always_ff @(posedge clk) begin
    if (rst || clear) upd_q <= 1'b0;
    else if (update)  upd_q <= cap_q;
  end

  assign scan_out = cap_q;
  assign sys_out  = mode ? upd_q : sys_in;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with instruction register, decoder, BYPASS,
// IDCODE and a chain of boundary-scan cells between the core and the pins.
//   clk     : TCK, rising edge
//   rst     : synchronous active-high reset, same effect as TRST
//   tms     : test mode select
//   tdi     : serial data in, shifted into the MSB of the selected register
//   tdo     : LSB of the selected shift register, 0 outside shift states
//   tdo_en  : high only in SHF_DR / SHF_IR
//   sys_in  : core-to-pin values
//   sys_out : pin values, sys_in or the BSR update stage under EXTEST
//   ir_out  : current (updated) instruction
//   state   : TAP state encoding for debug
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IR_LEN     = 4,
  parameter int unsigned BSR_LEN    = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1765_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_en,
  input  logic [BSR_LEN-1:0] sys_in,
  output logic [BSR_LEN-1:0] sys_out,
  output logic [IR_LEN-1:0]  ir_out,
  output logic [3:0]         state
);

  // ---------------------------------------------------------------------------
  // TAP state machine
  // ---------------------------------------------------------------------------
  tap_state_e state_q;
  tap_state_e state_d;

  logic cap_dr, shf_dr, upd_dr;
  logic cap_ir, shf_ir, upd_ir;
  logic tlr_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = tap_next(state_q, tms);
  end

  // Register strobes act on the edge that leaves the named state, so they are
  // decoded from the current state and applied by the next clock edge.
  // NOTE: every always_comb output is given a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cap_dr = 1'b0;
    shf_dr = 1'b0;
    upd_dr = 1'b0;
    cap_ir = 1'b0;
    shf_ir = 1'b0;
    upd_ir = 1'b0;
    tdo_en = 1'b0;
    case (state_q)
      CAP_DR: cap_dr = 1'b1;
      SHF_DR: begin shf_dr = 1'b1; tdo_en = 1'b1; end
      UPD_DR: upd_dr = 1'b1;
      CAP_IR: cap_ir = 1'b1;
      SHF_IR: begin shf_ir = 1'b1; tdo_en = 1'b1; end
      UPD_IR: upd_ir = 1'b1;
      default: ;
    endcase
  end

  // Entering or sitting in TLR behaves like reset for the IR and the update
  // stages, so ir_out is already IDCODE on the first TLR cycle.
  assign tlr_next = (state_d == TLR);
  assign state    = state_q;

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  logic [IR_LEN-1:0] ir_shift;
  logic [IR_LEN-1:0] ir_q;

  always_ff @(posedge clk) begin
    if (rst)         ir_shift <= '0;
    else if (cap_ir) ir_shift <= IR_LEN'(IR_CAPTURE);
    else if (shf_ir) ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst || tlr_next) ir_q <= IR_LEN'(OP_IDCODE);
    else if (upd_ir)     ir_q <= ir_shift;
  end

  assign ir_out = ir_q;

  // ---------------------------------------------------------------------------
  // Decode. Anything that is not EXTEST, SAMPLE or IDCODE selects BYPASS,
  // including the all-ones opcode.
  // ---------------------------------------------------------------------------
  logic sel_bsr;
  logic sel_id;
  logic sel_byp;
  logic extest;

  always_comb begin
    sel_bsr = 1'b0;
    sel_id  = 1'b0;
    if (ir_q == IR_LEN'(OP_EXTEST) || ir_q == IR_LEN'(OP_SAMPLE)) sel_bsr = 1'b1;
    else if (ir_q == IR_LEN'(OP_IDCODE))                         sel_id  = 1'b1;
  end

  assign sel_byp = !sel_bsr && !sel_id;
  assign extest  = (ir_q == IR_LEN'(OP_EXTEST));

  // ---------------------------------------------------------------------------
  // BYPASS and IDCODE data registers (no update stage)
  // ---------------------------------------------------------------------------
  logic        byp_q;
  logic [31:0] id_q;

  always_ff @(posedge clk) begin
    if (rst)                    byp_q <= 1'b0;
    else if (cap_dr && sel_byp) byp_q <= 1'b0;
    else if (shf_dr && sel_byp) byp_q <= tdi;
  end

  always_ff @(posedge clk) begin
    if (rst)                   id_q <= '0;
    else if (cap_dr && sel_id) id_q <= IDCODE_VAL;
    else if (shf_dr && sel_id) id_q <= {tdi, id_q[31:1]};
  end

  // ---------------------------------------------------------------------------
  // Boundary-scan chain: tdi enters at the MSB cell, tdo leaves from cell 0.
  // ---------------------------------------------------------------------------
  logic [BSR_LEN:0] bsr_chain;

  assign bsr_chain[BSR_LEN] = tdi;

  for (genvar i = 0; i < BSR_LEN; i++) begin : g_bsr
    jtag_bsr_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .clear    (tlr_next),
      .capture  (cap_dr && sel_bsr),
      .shift    (shf_dr && sel_bsr),
      .update   (upd_dr && sel_bsr),
      .mode     (extest),
      .sys_in   (sys_in[i]),
      .scan_in  (bsr_chain[i+1]),
      .scan_out (bsr_chain[i]),
      .sys_out  (sys_out[i])
    );
  end

  // ---------------------------------------------------------------------------
  // tdo mux: IR in SHF_IR, the decoded DR in SHF_DR, otherwise 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo = 1'b0;
    if (shf_ir) begin
      tdo = ir_shift[0];
    end else if (shf_dr) begin
      if (sel_bsr)     tdo = bsr_chain[0];
      else if (sel_id) tdo = id_q[0];
      else             tdo = byp_q;
    end
  end

endmodule
